// File: rtl/mem_lsu_pkg.sv
// Shared constants for the load/store unit: func3 codes, byte-enable
// bases and FSM state encoding.
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif

package mem_lsu_pkg;

   localparam int DATA_W = `CORE_XLEN;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_R,
      DONE
   } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational legality check, store lane steering and load
// extraction/extension.
module lsu_align
   import mem_lsu_pkg::*;
(
   input  logic              is_store,
   input  logic [2:0]        func3,
   input  logic [1:0]        off,
   input  logic [DATA_W-1:0] wdata,
   input  logic [2:0]        ld_func3,
   input  logic [1:0]        ld_off,
   input  logic [DATA_W-1:0] rdata,
   output logic              ok,
   output logic [3:0]        be,
   output logic [DATA_W-1:0] wdata_out,
   output logic [DATA_W-1:0] ld_ext
);

   logic        legal;
   logic        mis;
   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      legal     = 1'b0;
      mis       = 1'b0;
      be        = BE_WORD;
      wdata_out = '0;
      case (func3)
         F3_B:  legal = 1'b1;
         F3_H:  begin legal = 1'b1; mis = off[0]; end
         F3_W:  begin legal = 1'b1; mis = |off;   end
         F3_BU: legal = ~is_store;
         F3_HU: begin legal = ~is_store; mis = off[0]; end
         default: legal = 1'b0;
      endcase
      if (is_store) begin
         case (func3)
            F3_B: begin
               be        = BE_BYTE << off;
               wdata_out = {4{wdata[7:0]}};
            end
            F3_H: begin
               be        = BE_HALF << off;
               wdata_out = {2{wdata[15:0]}};
            end
            default: wdata_out = wdata;
         endcase
      end
      ok = legal & ~mis;
   end

   assign b = rdata[{ld_off, 3'b000} +: 8];
   assign h = rdata[{ld_off[1], 4'b0000} +: 16];

   always_comb begin
      ld_ext = rdata;
      case (ld_func3)
         F3_B:    ld_ext = {{24{b[7]}}, b};
         F3_H:    ld_ext = {{16{h[15]}}, h};
         F3_BU:   ld_ext = {24'd0, b};
         F3_HU:   ld_ext = {16'd0, h};
         default: ld_ext = rdata;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: bus FSM, timeout counter and registered bus/load
// outputs; stalls the core until the access retires.
module mem_lsu #(
   parameter int DATA_W      = mem_lsu_pkg::DATA_W,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_en,
   input  logic              is_store,
   input  logic [2:0]        func3,
   input  logic [DATA_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata_in,
   output logic              lsu_stall,
   output logic [DATA_W-1:0] ld_data,
   output logic              ld_valid,
   output logic              lsu_err,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [DATA_W-1:0] dbus_addr,
   output logic [DATA_W-1:0] dbus_wdata,
   output logic [3:0]        dbus_be,
   input  logic              dbus_gnt,
   input  logic              dbus_rvalid,
   input  logic [DATA_W-1:0] dbus_rdata
);

   import mem_lsu_pkg::*;

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   lsu_state_e        state;
   logic [2:0]        r_func3;
   logic [1:0]        r_off;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_nxt;
   logic              tmo;
   logic              ok;
   logic [3:0]        be;
   logic [DATA_W-1:0] wd;
   logic [DATA_W-1:0] ext;

   lsu_align u_align (
      .is_store  (is_store),
      .func3     (func3),
      .off       (addr_in[1:0]),
      .wdata     (wdata_in),
      .ld_func3  (r_func3),
      .ld_off    (r_off),
      .rdata     (dbus_rdata),
      .ok        (ok),
      .be        (be),
      .wdata_out (wd),
      .ld_ext    (ext)
   );

   assign cnt_nxt = cnt + 1'b1;
   assign tmo     = (cnt_nxt == CW'(TIMEOUT_CYC));

   assign lsu_stall = (state == IDLE && mem_en && ok)
                    || state == REQ || state == WAIT_R;

   // A completing handshake wins over a timeout in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         r_func3    <= '0;
         r_off      <= '0;
         ld_data    <= '0;
         ld_valid   <= 1'b0;
         lsu_err    <= 1'b0;
         dbus_req   <= 1'b0;
         dbus_we    <= 1'b0;
         dbus_addr  <= '0;
         dbus_wdata <= '0;
         dbus_be    <= '0;
      end else begin
         ld_valid <= 1'b0;
         lsu_err  <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (mem_en && ok) begin
                  r_func3    <= func3;
                  r_off      <= addr_in[1:0];
                  dbus_we    <= is_store;
                  dbus_addr  <= {addr_in[DATA_W-1:2], 2'b00};
                  dbus_wdata <= wd;
                  dbus_be    <= be;
                  dbus_req   <= 1'b1;
                  state      <= REQ;
               end else if (mem_en) begin
                  lsu_err <= 1'b1;
               end
            end
            REQ: begin
               if (dbus_gnt) begin
                  dbus_req <= 1'b0;
                  cnt      <= dbus_we ? '0 : cnt_nxt;
                  state    <= dbus_we ? DONE : WAIT_R;
               end else if (tmo) begin
                  dbus_req <= 1'b0;
                  lsu_err  <= 1'b1;
                  cnt      <= '0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            WAIT_R: begin
               if (dbus_rvalid) begin
                  ld_data  <= ext;
                  ld_valid <= 1'b1;
                  cnt      <= '0;
                  state    <= DONE;
               end else if (tmo) begin
                  lsu_err <= 1'b1;
                  cnt     <= '0;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stores, loads, illegal accesses,
// timeout and reset during an outstanding load.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_en;
   logic        to_mem_en;
   logic        is_store;
   logic [2:0]  func3;
   logic [31:0] addr_in;
   logic [31:0] wdata_in;
   logic        dbus_gnt;
   logic        dbus_rvalid;
   logic [31:0] dbus_rdata;

   logic        lsu_stall, ld_valid, lsu_err;
   logic        dbus_req, dbus_we;
   logic [31:0] ld_data, dbus_addr, dbus_wdata;
   logic [3:0]  dbus_be;

   logic        to_stall, to_ld_valid, to_err, to_req, to_we;
   logic [31:0] to_ld_data, to_addr, to_wdata;
   logic [3:0]  to_be;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_lsu dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_en      (mem_en),
      .is_store    (is_store),
      .func3       (func3),
      .addr_in     (addr_in),
      .wdata_in    (wdata_in),
      .lsu_stall   (lsu_stall),
      .ld_data     (ld_data),
      .ld_valid    (ld_valid),
      .lsu_err     (lsu_err),
      .dbus_req    (dbus_req),
      .dbus_we     (dbus_we),
      .dbus_addr   (dbus_addr),
      .dbus_wdata  (dbus_wdata),
      .dbus_be     (dbus_be),
      .dbus_gnt    (dbus_gnt),
      .dbus_rvalid (dbus_rvalid),
      .dbus_rdata  (dbus_rdata)
   );

   mem_lsu #(.TIMEOUT_CYC(4)) dut_to (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_en      (to_mem_en),
      .is_store    (is_store),
      .func3       (func3),
      .addr_in     (addr_in),
      .wdata_in    (wdata_in),
      .lsu_stall   (to_stall),
      .ld_data     (to_ld_data),
      .ld_valid    (to_ld_valid),
      .lsu_err     (to_err),
      .dbus_req    (to_req),
      .dbus_we     (to_we),
      .dbus_addr   (to_addr),
      .dbus_wdata  (to_wdata),
      .dbus_be     (to_be),
      .dbus_gnt    (1'b0),
      .dbus_rvalid (1'b0),
      .dbus_rdata  (32'd0)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      tick();
      mem_en   = 1'b1;
      is_store = st;
      func3    = f3;
      addr_in  = a;
      wdata_in = wd;
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gdly, input logic [3:0] xbe,
                           input logic [31:0] xwd);
      issue(1'b1, f3, a, wd);
      @(negedge clk);
      chk({tag, " stall0"}, lsu_stall, 1);
      chk({tag, " req0"}, dbus_req, 0);
      tick();
      mem_en = 1'b0;
      for (int i = 0; i < gdly; i++) begin
         @(negedge clk);
         chk({tag, " reqw"}, dbus_req, 1);
         chk({tag, " stallw"}, lsu_stall, 1);
         tick();
      end
      dbus_gnt = 1'b1;
      @(negedge clk);
      chk({tag, " req"}, dbus_req, 1);
      chk({tag, " we"}, dbus_we, 1);
      chk({tag, " addr"}, dbus_addr, {a[31:2], 2'b00});
      chk({tag, " be"}, dbus_be, xbe);
      chk({tag, " wdata"}, dbus_wdata, xwd);
      chk({tag, " stall1"}, lsu_stall, 1);
      tick();
      dbus_gnt = 1'b0;
      @(negedge clk);
      chk({tag, " done stall"}, lsu_stall, 0);
      chk({tag, " done req"}, dbus_req, 0);
      chk({tag, " no ldv"}, ld_valid, 0);
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rd,
                          input int rdly, input logic [31:0] exp);
      issue(1'b0, f3, a, 32'h5555_5555);
      @(negedge clk);
      chk({tag, " stall0"}, lsu_stall, 1);
      tick();
      mem_en   = 1'b0;
      dbus_gnt = 1'b1;
      @(negedge clk);
      chk({tag, " req"}, dbus_req, 1);
      chk({tag, " we"}, dbus_we, 0);
      chk({tag, " addr"}, dbus_addr, {a[31:2], 2'b00});
      chk({tag, " be"}, dbus_be, 4'hF);
      chk({tag, " wdata"}, dbus_wdata, 0);
      tick();
      dbus_gnt = 1'b0;
      for (int i = 0; i < rdly - 1; i++) begin
         @(negedge clk);
         chk({tag, " wait req"}, dbus_req, 0);
         chk({tag, " wait stall"}, lsu_stall, 1);
         chk({tag, " wait ldv"}, ld_valid, 0);
         tick();
      end
      dbus_rvalid = 1'b1;
      dbus_rdata  = rd;
      @(negedge clk);
      chk({tag, " rv stall"}, lsu_stall, 1);
      tick();
      dbus_rvalid = 1'b0;
      dbus_rdata  = 32'h0;
      @(negedge clk);
      chk({tag, " ldv"}, ld_valid, 1);
      chk({tag, " data"}, ld_data, exp);
      chk({tag, " done stall"}, lsu_stall, 0);
      tick();
      @(negedge clk);
      chk({tag, " ldv off"}, ld_valid, 0);
   endtask

   task automatic do_illegal(input string tag, input logic st,
                             input logic [2:0] f3, input logic [31:0] a);
      issue(st, f3, a, 32'h1234_5678);
      @(negedge clk);
      chk({tag, " stall"}, lsu_stall, 0);
      tick();
      mem_en = 1'b0;
      @(negedge clk);
      chk({tag, " err"}, lsu_err, 1);
      chk({tag, " req"}, dbus_req, 0);
      chk({tag, " stall1"}, lsu_stall, 0);
      tick();
      @(negedge clk);
      chk({tag, " err off"}, lsu_err, 0);
      chk({tag, " req off"}, dbus_req, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b0;
      mem_en      = 1'b0;
      to_mem_en   = 1'b0;
      is_store    = 1'b0;
      func3       = 3'b000;
      addr_in     = 32'h0;
      wdata_in    = 32'h0;
      dbus_gnt    = 1'b0;
      dbus_rvalid = 1'b0;
      dbus_rdata  = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst stall", lsu_stall, 0);
      chk("rst req", dbus_req, 0);
      chk("rst ldv", ld_valid, 0);
      chk("rst err", lsu_err, 0);
      chk("rst be", dbus_be, 0);
      rst_n = 1'b1;

      do_store("sw", 3'b010, 32'h100, 32'hDEAD_BEEF, 1, 4'hF, 32'hDEAD_BEEF);
      do_store("sb", 3'b000, 32'h103, 32'h0000_00A5, 0, 4'h8, 32'hA5A5_A5A5);
      do_store("sh", 3'b001, 32'h202, 32'h1234_BEEF, 0, 4'hC, 32'hBEEF_BEEF);

      do_load("lb", 3'b000, 32'h102, 32'h0080_0000, 3, 32'hFFFF_FF80);
      do_load("lbu", 3'b100, 32'h102, 32'h0080_0000, 3, 32'h0000_0080);
      do_load("lh", 3'b001, 32'h102, 32'h8001_0000, 1, 32'hFFFF_8001);
      do_load("lhu", 3'b101, 32'h100, 32'h1234_ABCD, 1, 32'h0000_ABCD);
      do_load("lw", 3'b010, 32'h104, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);

      do_illegal("lh mis", 1'b0, 3'b001, 32'h101);
      do_illegal("ld f3=011", 1'b0, 3'b011, 32'h100);
      do_illegal("st f3=100", 1'b1, 3'b100, 32'h100);
      do_illegal("sw mis", 1'b1, 3'b010, 32'h102);

      tick();
      to_mem_en = 1'b1;
      is_store  = 1'b1;
      func3     = 3'b010;
      addr_in   = 32'h200;
      wdata_in  = 32'h0BAD_0BAD;
      @(negedge clk);
      chk("to stall0", to_stall, 1);
      tick();
      to_mem_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("to req", to_req, 1);
         chk("to err early", to_err, 0);
         tick();
      end
      @(negedge clk);
      chk("to err", to_err, 1);
      chk("to req drop", to_req, 0);
      chk("to stall", to_stall, 0);
      chk("to ldv", to_ld_valid, 0);
      tick();
      @(negedge clk);
      chk("to err off", to_err, 0);
      chk("to idle stall", to_stall, 0);

      issue(1'b0, 3'b010, 32'h300, 32'h0);
      tick();
      mem_en   = 1'b0;
      dbus_gnt = 1'b1;
      tick();
      dbus_gnt = 1'b0;
      @(negedge clk);
      chk("wr stall", lsu_stall, 1);
      rst_n = 1'b0;
      #1;
      chk("wr rst stall", lsu_stall, 0);
      chk("wr rst req", dbus_req, 0);
      chk("wr rst addr", dbus_addr, 0);
      chk("wr rst data", ld_data, 0);
      chk("wr rst ldv", ld_valid, 0);
      tick();
      rst_n       = 1'b1;
      dbus_rvalid = 1'b1;
      dbus_rdata  = 32'h7777_7777;
      @(negedge clk);
      chk("late rv ldv", ld_valid, 0);
      tick();
      dbus_rvalid = 1'b0;
      dbus_rdata  = 32'h0;
      @(negedge clk);
      chk("late rv ldv2", ld_valid, 0);
      chk("late rv data", ld_data, 0);
      chk("late rv stall", lsu_stall, 0);

      do_load("lw post", 3'b010, 32'h300, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
